// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequencing front-end of the datapath ALU:
// op encodings, FSM states and the shift-add multiply iteration count.
package alu_seq_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq.sv
// Request/response sequencer around an external combinational ALU. ADD/SUB/OR
// take one ALU cycle; MUL is a fixed 32-iteration shift-add using the ALU adder.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [DATA_W-1:0] req_a_i,
    input  logic [DATA_W-1:0] req_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic [DATA_W-1:0] alu_src0_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [1:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_zero_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid/payload are not required to be held otherwise.

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    // a_q/b_q double as multiplicand/multiplier while in ST_MUL
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  acc_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        count_d     = count_q;
        acc_next    = acc_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        alu_src0_o  = '0;
        alu_src1_o  = '0;
        alu_op_o    = OP_ADD;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d    = op_e'(req_op_i);
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = (op_e'(req_op_i) == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src0_o = a_q;
                alu_src1_o = b_q;
                alu_op_o   = op_q;
                result_d   = alu_out_i;
                zero_d     = alu_zero_i;
                state_d    = ST_DONE;
            end
            ST_MUL: begin
                alu_src0_o = acc_q;
                alu_src1_o = a_q;
                alu_op_o   = OP_ADD;
                acc_next   = b_q[0] ? alu_out_i : acc_q;
                acc_d      = acc_next;
                a_d        = a_q << 1;
                b_d        = b_q >> 1;
                count_d    = count_q + 1'b1;
                // The last iteration's sum goes straight into the result.
                if (count_q == CNT_W'(MUL_ITERS - 1)) begin
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU beside the DUT, vector table with a
// response queue, plus hand sequences for backpressure, reset abort, back-to-back.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_src0;
    logic [31:0] alu_src1;
    logic [1:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero;

    alu_seq dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .alu_src0_o   (alu_src0),
        .alu_src1_o   (alu_src1),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .alu_zero_i   (alu_zero)
    );

    // Datapath ALU stand-in
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_src0 + alu_src1;
            2'b01:   alu_out = alu_src0 - alu_src1;
            2'b10:   alu_out = alu_src0 | alu_src1;
            default: alu_out = 32'h0;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int total;
    int bad;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a | b;
            default: r = a * b;
        endcase
        return {(r == 32'h0), r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_r, input logic exp_z);
        @(negedge clk);
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        exp_q.push_back({exp_z, exp_r});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 100);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic consume(input string name);
        logic [32:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_queue: got empty want entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_result"}, rsp_result, e[31:0]);
            check({name, "_zero"}, {31'b0, rsp_zero}, {31'b0, e[32]});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_valid_after_hs"}, {31'b0, rsp_valid}, 32'd0);
        check({name, "_ready_after_hs"}, {31'b0, req_ready}, 32'd1);
    endtask

    function automatic int lat_of(input logic [1:0] op);
        return (op == 2'b11) ? 32 : 1;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [32:0] m;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b0;

        vecs.push_back('{2'b00, 32'd5, 32'd7, 32'd12, 1'b0});
        vecs.push_back('{2'b01, 32'd9, 32'd9, 32'd0, 1'b1});
        vecs.push_back('{2'b10, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0});
        vecs.push_back('{2'b11, 32'd6, 32'd7, 32'd42, 1'b0});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1});
        vecs.push_back('{2'b01, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{2'b11, 32'd0, 32'h1234_5678, 32'h0, 1'b1});
        for (int i = 0; i < 8; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.a  = $urandom;
            v.b  = $urandom;
            m    = model(v.op, v.a, v.b);
            v.r  = m[31:0];
            v.z  = m[32];
            vecs.push_back(v);
        end

        // Reset values
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_zero", {31'b0, rsp_zero}, 32'd0);
        check("rst_src0", alu_src0, 32'h0);
        check("rst_src1", alu_src1, 32'h0);
        check("rst_op", {30'b0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            drive_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].z);
            wait_valid($sformatf("vec%0d", i), lat_of(vecs[i].op));
            consume($sformatf("vec%0d", i));
            check($sformatf("vec%0d_idle_hold", i), rsp_result, vecs[i].r);
        end

        // Backpressure in DONE with a competing request
        drive_req(2'b00, 32'd10, 32'd20, 32'd30, 1'b0);
        wait_valid("bp", 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 2'b01;
            req_a     = 32'd1;
            req_b     = 32'd2;
            check("bp_result_stable", rsp_result, 32'd30);
            check("bp_valid_held", {31'b0, rsp_valid}, 32'd1);
            check("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
            check("bp_alu_src0_idle", alu_src0, 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        consume("bp");
        @(negedge clk);
        check("bp_no_stray_accept", {31'b0, req_ready}, 32'd1);
        check("bp_idle_result", rsp_result, 32'd30);

        // Reset during MUL iteration 10
        drive_req(2'b11, 32'd6, 32'd7, 32'd42, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("mrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mrst_result", rsp_result, 32'h0);
        check("mrst_src0", alu_src0, 32'h0);
        check("mrst_src1", alu_src1, 32'h0);
        repeat (3) @(negedge clk);
        check("mrst_hold_ready", {31'b0, req_ready}, 32'd1);
        check("mrst_hold_valid", {31'b0, rsp_valid}, 32'd0);
        check("mrst_hold_zero", {31'b0, rsp_zero}, 32'd0);
        // First acceptance on the first edge after release
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd1;
        req_b     = 32'd1;
        exp_q.push_back({1'b0, 32'd2});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mrst_first_accept", {31'b0, req_ready}, 32'd0);
        wait_valid("mrst_add", 1);
        consume("mrst_add");

        // Back-to-back: ADD then MUL with req_valid held high
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd3;
        req_b     = 32'd4;
        exp_q.push_back({1'b0, 32'd7});
        @(posedge clk);
        #1;
        req_op = 2'b11;
        req_a  = 32'd5;
        req_b  = 32'd6;
        exp_q.push_back({1'b0, 32'd30});
        wait_valid("b2b_add", 1);
        consume("b2b_add");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_mul_accepted", {31'b0, req_ready}, 32'd0);
        wait_valid("b2b_mul", 32);
        consume("b2b_mul");

        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
